// File: rtl/wb_select_pipe_if.sv
// Writeback selector bus: upstream result handshake plus selection operands,
// and the downstream register-file write handshake with the retired-write count.
// master = producer/consumer side (execute stage + register file), slave = wb_select_pipe.
interface wb_select_pipe_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       WDSel;
   logic [2:0]       DMType;
   logic [1:0]       addr_lo;
   logic [XLEN-1:0]  aluout;
   logic [XLEN-1:0]  dout;
   logic [XLEN-1:0]  PC_out;
   logic [XLEN-1:0]  imm;
   logic [4:0]       rd;
   logic             RegWrite;
   logic             wb_valid;
   logic             wb_ready;
   logic [XLEN-1:0]  WD;
   logic [4:0]       wb_rd;
   logic             wb_we;
   logic [CNT_W-1:0] wb_count;

   modport master (
      output in_valid, WDSel, DMType, addr_lo, aluout, dout, PC_out, imm, rd, RegWrite, wb_ready,
      input  in_ready, wb_valid, WD, wb_rd, wb_we, wb_count
   );

   modport slave (
      input  in_valid, WDSel, DMType, addr_lo, aluout, dout, PC_out, imm, rd, RegWrite, wb_ready,
      output in_ready, wb_valid, WD, wb_rd, wb_we, wb_count
   );
endinterface

// File: rtl/wb_select_pipe.sv
// Purpose: select/extend RISC-V writeback data and hold it in a 2-entry skid buffer.
// Latency: 1 cycle from accept edge to wb_valid/WD.
// Backpressure: wb_ready low parks one extra entry in skid; in_ready (registered) drops while skid is full.
// Ports: clk, rstn (async active-low); io_bus carries in_valid/in_ready + operands,
//        wb_valid/wb_ready + WD/wb_rd/wb_we, and the retired-write counter wb_count.
module wb_select_pipe #(
   parameter int XLEN   = 32,
   parameter int PC_INC = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rstn,
   wb_select_pipe_if.slave  io_bus
);

   typedef struct packed {
      logic [XLEN-1:0] wd;
      logic [4:0]      rd;
      logic            we;
   } entry_t;

   // State encoding is {skid_valid, main_valid}.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   entry_t           r_main;
   entry_t           r_skid;
   entry_t           w_entry;
   logic             r_in_rdy;
   logic [CNT_W-1:0] r_count;

   logic             w_main_vld;
   logic             w_acc;
   logic             w_cons;
   logic             w_load_main;
   logic             w_load_skid;
   logic             w_skid_to_main;
   logic [15:0]      w_half;
   logic [7:0]       w_byte;
   logic [XLEN-1:0]  w_load_data;
   logic [XLEN-1:0]  w_sel_data;

   // ---------------- input-side selection ----------------
   assign w_half = io_bus.addr_lo[1] ? io_bus.dout[31:16] : io_bus.dout[15:0];

   always_comb begin
      w_byte = io_bus.dout[7:0];
      case (io_bus.addr_lo)
         2'd0:    w_byte = io_bus.dout[7:0];
         2'd1:    w_byte = io_bus.dout[15:8];
         2'd2:    w_byte = io_bus.dout[23:16];
         default: w_byte = io_bus.dout[31:24];
      endcase
   end

   // Unknown DMType codes fall back to a full-word load.
   always_comb begin
      w_load_data = io_bus.dout;
      case (io_bus.DMType)
         3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
         3'b010:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
         3'b011:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
         default: w_load_data = io_bus.dout;
      endcase
   end

   always_comb begin
      w_sel_data = io_bus.aluout;
      case (io_bus.WDSel)
         2'b00:   w_sel_data = io_bus.aluout;
         2'b01:   w_sel_data = w_load_data;
         2'b10:   w_sel_data = io_bus.PC_out + XLEN'(PC_INC);
         default: w_sel_data = io_bus.imm;
      endcase
   end

   // x0 writes still travel through the pipe so commit order is preserved.
   assign w_entry.wd = w_sel_data;
   assign w_entry.rd = io_bus.rd;
   assign w_entry.we = io_bus.RegWrite && (io_bus.rd != 5'd0);

   // ---------------- skid buffer control ----------------
   assign w_main_vld = (r_state != EMPTY);
   assign w_acc      = io_bus.in_valid && r_in_rdy;
   assign w_cons     = w_main_vld && io_bus.wb_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_acc) begin
               w_state_nxt = ONE;
               w_load_main = 1'b1;
            end
         end
         ONE: begin
            if (w_acc && w_cons) begin
               w_load_main = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = FULL;
               w_load_skid = 1'b1;
            end else if (w_cons) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so no accept can coincide with the drain.
            if (w_cons) begin
               w_state_nxt    = ONE;
               w_skid_to_main = 1'b1;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // in_ready is computed from the next state so it is a pure flop output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= EMPTY;
         r_in_rdy <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_in_rdy <= (w_state_nxt != FULL);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main) begin
            r_main <= w_entry;
         end else if (w_skid_to_main) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_entry;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (w_cons && r_main.we) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign io_bus.in_ready = r_in_rdy;
   assign io_bus.wb_valid = w_main_vld;
   assign io_bus.WD       = r_main.wd;
   assign io_bus.wb_rd    = r_main.rd;
   assign io_bus.wb_we    = r_main.we;
   assign io_bus.wb_count = r_count;

endmodule

// File: doc/wb_select_pipe.md
# wb_select_pipe

Parametrised, registered writeback selector for the RISC-V core. Selects the register-file write data from the ALU result, memory load data, the return address or the U-type immediate. Aligns and sign/zero-extends sub-word loads. Holds the result in a two-entry valid/ready skid buffer between execute/memory and the register-file write port. Adds a 1-cycle pipeline stage, back-pressure, x0 write suppression and a retired-write counter.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- PC_INC, 4, added to PC_out for the link value (`WDSel_FromPC`)
- CNT_W, 16, width of the retired-write counter

Ports:
- clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  block can accept this cycle
- WDSel  in  2  00 ALU, 01 MEM, 10 PC+PC_INC, 11 IMM
- DMType  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw
- addr_lo  in  2  low bits of the load byte address
- aluout  in  XLEN  ALU result
- dout  in  XLEN  raw aligned data-memory word
- PC_out  in  XLEN  PC of the instruction
- imm  in  XLEN  U-type immediate
- rd  in  5  destination register
- RegWrite  in  1  instruction writes rd
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  register file accepts the entry
- WD  out  XLEN  write data
- wb_rd  out  5  write address
- wb_we  out  1  write enable: RegWrite && rd != 0
- wb_count  out  CNT_W  count of accepted entries with wb_we=1

## Operation
- Input accepted when in_valid && in_ready. Output consumed when wb_valid && wb_ready.
- Data selection is combinational on the input side. Only the selected, extended value is stored.
  - MEM/lw: dout.
  - MEM/lh, lhu: half = addr_lo[1] ? dout[31:16] : dout[15:0], sign- or zero-extended to XLEN.
  - MEM/lb, lbu: byte lane dout[8*addr_lo+7 : 8*addr_lo], sign- or zero-extended.
  - PC: PC_out + PC_INC, modulo 2^XLEN.
  - IMM: imm.
  - ALU: aluout.
- Storage is two entries: an output register (main) and a skid register (skid). Each entry holds {WD, rd, we}.
- States, encoded as valid bits:
  - EMPTY: main empty, skid empty.
  - ONE: main valid, skid empty.
  - FULL: main valid, skid valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no consume -> FULL; input captured into skid.
  - ONE + accept + consume -> ONE; main reloaded from input.
  - ONE + consume only -> EMPTY.
  - FULL + consume -> ONE; skid moves to main.
- in_ready = !skid_valid. It is registered, so it has no combinational path from wb_ready.
- wb_count increments by 1 per consume with wb_we=1. It wraps from 2^CNT_W-1 to 0.
- rd=0 or RegWrite=0: the entry still flows through with we=0. This keeps ordering for trace/commit and does not increment the counter.

## Timing
- Latency: input accepted at edge N appears on WD/wb_rd/wb_we with wb_valid=1 after edge N.
- Throughput: 1 entry per cycle while wb_ready=1.
- Back-pressure:
  - wb_ready low for 1 cycle absorbs one extra entry into skid.
  - in_ready drops the cycle after FULL is entered.
  - in_ready rises the cycle after the first consume from FULL.
- While wb_valid=1 and wb_ready=0, WD, wb_rd and wb_we are held stable.
- Reset (rstn low, asynchronous) applies immediately:
  - wb_valid=0, WD=0, wb_rd=0, wb_we=0, wb_count=0.
  - Skid cleared; in_ready=1 from the first edge after release.
  - In-flight entries are discarded.
- Simultaneous accept + consume in FULL cannot occur (in_ready=0).

## Test plan
- Selection: WDSel=10, PC_out=0x100 -> WD=0x104 one cycle later. WDSel=11, imm=0x12345000 -> WD=0x12345000. WDSel=00, aluout=7 -> WD=7.
- Load extension: dout=0x80FF7F01.
  - lb, addr_lo=3 -> 0xFFFFFF80.
  - lbu, addr_lo=1 -> 0x0000007F.
  - lh, addr_lo=2 -> 0xFFFF80FF.
  - lhu, addr_lo=0 -> 0x00007F01.
  - lw -> 0x80FF7F01.
- Back-pressure: stream A,B,C,D with wb_ready low for cycles 2-3.
  - in_ready=0 while both entries are full.
  - Outputs appear in order A,B,C,D with no loss or duplication.
  - WD is stable while stalled.
- x0 suppression: RegWrite=1, rd=0 -> wb_valid=1, wb_we=0, wb_count unchanged. RegWrite=1, rd=5 -> wb_we=1, wb_count+1.
- Counter wrap: CNT_W=4, 17 writing entries consumed -> wb_count=1.
- Reset mid-stream: assert rstn=0 while FULL -> wb_valid=0, WD=0, wb_count=0 immediately; in_ready=1 after release; the next entry appears with 1-cycle latency.
